// File: rtl/fifo_bit_serializer.sv
// ---------------------------------------------------------------------------
// fifo_bit_serializer
//
// Pulls bytes from the telemetry byte FIFO through its registered read port
// and shifts them out one bit per qualified bit-rate strobe. One byte is
// prefetched into a holding register. If no byte is held at a byte boundary,
// a fill byte is shifted out so the serial stream never stalls, and a sticky
// underflow flag is set.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   clkEn          clock enable; all state advances only when high
//   enable         serializer run enable
//   bitEn          bit-rate strobe, qualified as clkEn & enable & bitEn
//   fifoEmpty      FIFO empty flag
//   fifoDout[7:0]  FIFO registered read data
//   fifoRdEn       FIFO read request (registered)
//   bitOut         serial data bit (registered)
//   bitStrobe      one-clk pulse coincident with each new bitOut
//   bitIsData      1 = current bitOut came from a FIFO byte, 0 = fill
//   clrUnderflow   clears underflow; wins over a same-cycle set
//   underflow      sticky: fill byte loaded since last clear
//   dbg_state      fetch FSM state: 0=IDLE 1=READ 2=WAIT 3=CAP
//   dbg_hold_valid holding register occupied
//   dbg_hold_byte  holding register contents
//   dbg_bits_left  bits of the current byte still to be shifted
//
// FIFO handshake: the FIFO is "valid" when fifoEmpty=0. A pop is requested
// by holding fifoRdEn high for exactly one clkEn-qualified cycle; the popped
// byte appears on fifoDout one clkEn cycle later (registered read data) and
// is captured one cycle after that. Only one pop is ever outstanding, and a
// pop is never requested while fifoEmpty=1.
// ---------------------------------------------------------------------------
module fifo_bit_serializer #(
  parameter logic [7:0] FILL_BYTE = 8'h55,
  parameter bit         MSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clkEn,
  input  logic       enable,
  input  logic       bitEn,
  input  logic       fifoEmpty,
  input  logic [7:0] fifoDout,
  output logic       fifoRdEn,
  output logic       bitOut,
  output logic       bitStrobe,
  output logic       bitIsData,
  input  logic       clrUnderflow,
  output logic       underflow,
  output logic [1:0] dbg_state,
  output logic       dbg_hold_valid,
  output logic [7:0] dbg_hold_byte,
  output logic [2:0] dbg_bits_left
);

  // Fetch FSM encoding.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] CAP  = 2'd3;

  logic [1:0] state;
  logic [7:0] hold_byte;
  logic       hold_valid;
  logic [2:0] bits_left;
  logic [7:0] shreg;

  logic       bit_qual;
  logic       at_boundary;
  logic       fetch_start;
  logic       hold_take;
  logic       fill_load;
  logic [7:0] load_byte;
  logic [7:0] shift_src;
  logic       out_bit;
  logic [7:0] shifted;

  // -------------------------------------------------------------------------
  // Shifter datapath
  // -------------------------------------------------------------------------
  always_comb begin
    bit_qual    = clkEn & enable & bitEn;
    at_boundary = (bits_left == 3'd0);
    // A byte captured on this same edge is not visible here (hold_valid is
    // still 0 in CAP), so a coincident boundary takes fill. This is
    // intentional: no bypass from fifoDout into the shifter.
    hold_take   = bit_qual & at_boundary & hold_valid;
    fill_load   = bit_qual & at_boundary & ~hold_valid;
    fetch_start = enable & ~hold_valid & ~fifoEmpty;

    load_byte   = hold_valid ? hold_byte : FILL_BYTE;
    // At a boundary the first bit comes straight from the byte being loaded;
    // otherwise from the shift register holding the remaining bits.
    shift_src   = at_boundary ? load_byte : shreg;
    if (MSB_FIRST) begin
      out_bit = shift_src[7];
      shifted = {shift_src[6:0], 1'b0};
    end else begin
      out_bit = shift_src[0];
      shifted = {1'b0, shift_src[7:1]};
    end
  end

  // -------------------------------------------------------------------------
  // Fetch FSM and holding register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      fifoRdEn   <= 1'b0;
      hold_byte  <= 8'h00;
      hold_valid <= 1'b0;
    end else if (clkEn) begin
      case (state)
        IDLE: begin
          if (fetch_start) begin
            state    <= READ;
            fifoRdEn <= 1'b1;
          end
        end
        READ: begin
          state    <= WAIT;
          fifoRdEn <= 1'b0;
        end
        // fifoDout now carries the popped byte; capture on the next edge.
        WAIT: state <= CAP;
        CAP: begin
          hold_byte <= fifoDout;
          state     <= IDLE;
        end
        default: begin
          state    <= IDLE;
          fifoRdEn <= 1'b0;
        end
      endcase

      // CAP and hold_take are mutually exclusive (hold_valid=0 outside IDLE),
      // so set/clear order does not matter.
      if (state == CAP) begin
        hold_valid <= 1'b1;
      end else if (hold_take) begin
        hold_valid <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Serial shifter and output flags
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      bits_left <= 3'd0;
      shreg     <= 8'h00;
      bitOut    <= 1'b0;
      bitStrobe <= 1'b0;
      bitIsData <= 1'b0;
      underflow <= 1'b0;
    end else begin
      // bit_qual already includes clkEn, so the pulse also drops on
      // clkEn-low cycles.
      bitStrobe <= bit_qual;

      if (clkEn) begin
        if (!enable) begin
          // A partially shifted byte is discarded; bitOut holds.
          bits_left <= 3'd0;
        end else if (bit_qual) begin
          bitOut <= out_bit;
          shreg  <= shifted;
          if (at_boundary) begin
            bits_left <= 3'd7;
            bitIsData <= hold_valid;
          end else begin
            bits_left <= bits_left - 3'd1;
          end
        end

        if (clrUnderflow) begin
          underflow <= 1'b0;
        end else if (fill_load) begin
          underflow <= 1'b1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Debug visibility
  // -------------------------------------------------------------------------
  assign dbg_state      = state;
  assign dbg_hold_valid = hold_valid;
  assign dbg_hold_byte  = hold_byte;
  assign dbg_bits_left  = bits_left;

endmodule

// File: tb/tb_fifo_bit_serializer.sv
// ---------------------------------------------------------------------------
// tb_fifo_bit_serializer
//
// Bench for fifo_bit_serializer (FILL_BYTE=8'h55, MSB_FIRST=1). A queue
// stands in for the byte FIFO with a one-stage registered read port. A
// transaction-level reference model tracks the held byte, the bits left of
// the current byte as a bit queue, and the fetch as a countdown of clkEn
// cycles, and predicts every output each clock.
// ---------------------------------------------------------------------------
module tb_fifo_bit_serializer;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       clkEn = 1'b0;
  logic       enable = 1'b0;
  logic       bitEn = 1'b0;
  logic       fifoEmpty = 1'b1;
  logic [7:0] fifoDout = 8'h00;
  logic       clrUnderflow = 1'b0;
  logic       fifoRdEn, bitOut, bitStrobe, bitIsData, underflow;
  logic [1:0] dbg_state;
  logic       dbg_hold_valid;
  logic [7:0] dbg_hold_byte;
  logic [2:0] dbg_bits_left;

  fifo_bit_serializer #(.FILL_BYTE(8'h55), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .clkEn(clkEn), .enable(enable), .bitEn(bitEn),
    .fifoEmpty(fifoEmpty), .fifoDout(fifoDout), .fifoRdEn(fifoRdEn),
    .bitOut(bitOut), .bitStrobe(bitStrobe), .bitIsData(bitIsData),
    .clrUnderflow(clrUnderflow), .underflow(underflow),
    .dbg_state(dbg_state), .dbg_hold_valid(dbg_hold_valid),
    .dbg_hold_byte(dbg_hold_byte), .dbg_bits_left(dbg_bits_left)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  // ---------------- FIFO stand-in and reference model ----------------
  logic [7:0] fifo_q[$];
  logic [0:0] exp_q[$];

  int         m_cd = 0;          // clkEn cycles left in fetch (3=READ .. 1=CAP)
  logic [7:0] m_pending = 8'h00; // byte the fetch in flight will deliver
  logic [7:0] m_hold_q[$];       // held byte (0 or 1 entries)
  logic       m_cur_q[$];        // bits of the current byte not yet shifted
  logic       m_bit = 1'b0, m_strobe = 1'b0, m_isdata = 1'b0, m_uf = 1'b0;
  logic       m_rden = 1'b0, m_hold_valid = 1'b0;

  wire [5:0] act_v = {fifoRdEn, bitOut, bitStrobe, bitIsData, underflow, dbg_hold_valid};
  wire [5:0] exp_v = {m_rden, m_bit, m_strobe, m_isdata, m_uf, m_hold_valid};

  always @(posedge clk) begin : model_b
    logic       qual;
    logic       hold_was_empty;
    logic [7:0] b;
    if (reset) begin
      m_cd = 0;
      m_hold_q.delete();
      m_cur_q.delete();
      m_bit = 1'b0; m_strobe = 1'b0; m_isdata = 1'b0; m_uf = 1'b0;
    end else begin
      qual = clkEn & enable & bitEn;
      m_strobe = qual;
      if (clkEn) begin
        hold_was_empty = (m_hold_q.size() == 0);
        if (qual) begin
          if (m_cur_q.size() == 0) begin
            if (!hold_was_empty) begin
              b = m_hold_q.pop_front();
              m_isdata = 1'b1;
            end else begin
              b = 8'h55;
              m_isdata = 1'b0;
              m_uf = 1'b1;
            end
            for (int i = 0; i < 8; i++) m_cur_q.push_back(b[7-i]);
          end
          m_bit = m_cur_q.pop_front();
        end
        if (!enable) m_cur_q.delete();
        if (clrUnderflow) m_uf = 1'b0;
        if (m_cd == 0) begin
          if (enable && hold_was_empty && fifo_q.size() > 0) begin
            m_cd = 3;
            m_pending = fifo_q[0];
          end
        end else begin
          if (m_cd == 3 && fifo_q.size() > 0) fifoDout <= fifo_q.pop_front();
          m_cd = m_cd - 1;
          if (m_cd == 0) m_hold_q.push_back(m_pending);
        end
      end
    end
    m_rden = (m_cd == 3);
    m_hold_valid = (m_hold_q.size() != 0);
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    fifoEmpty = (fifo_q.size() == 0);
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    fifoEmpty = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; clkEn = 1'b1; enable = 1'b0; bitEn = 1'b0; clrUnderflow = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; clkEn = 1'b1; enable = 1'b1; bitEn = 1'b1; clrUnderflow = 1'b0;
    cycle();
    cycle();
    vec_cnt++;
    if (act_v !== 6'b0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got %b expected %b", act_v, 6'b0);
    end
    vec_cnt++;
    if (dbg_state !== 2'd0) begin
      err_cnt++;
      $display("FAIL reset_state: got %0d expected 0", dbg_state);
    end
    vec_cnt++;
    if (dbg_bits_left !== 3'd0) begin
      err_cnt++;
      $display("FAIL reset_bits_left: got %0d expected 0", dbg_bits_left);
    end
    reset = 1'b0; enable = 1'b0; bitEn = 1'b0;
  endtask

  task automatic test_fetch_timing();
    int first_rd = -1;
    int rd_cycles = 0;
    do_reset();
    push_byte(8'hA5);
    enable = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      cycle();
      vec_cnt++;
      if (act_v !== exp_v) begin
        err_cnt++;
        $display("FAIL fetch_timing cyc %0d: got %b expected %b", c, act_v, exp_v);
      end
      if (fifoRdEn) begin
        rd_cycles++;
        if (first_rd < 0) first_rd = c;
      end
      if (first_rd > 0 && c == first_rd + 3) begin
        vec_cnt++;
        if ({dbg_hold_valid, dbg_hold_byte} !== {1'b1, 8'hA5}) begin
          err_cnt++;
          $display("FAIL fetch_hold_byte: got %b/%h expected 1/a5", dbg_hold_valid, dbg_hold_byte);
        end
      end
    end
    vec_cnt++;
    if (rd_cycles !== 1) begin
      err_cnt++;
      $display("FAIL fetch_rden_width: got %0d clks expected 1", rd_cycles);
    end
    vec_cnt++;
    if (first_rd !== 1) begin
      err_cnt++;
      $display("FAIL fetch_rden_first: got cyc %0d expected 1", first_rd);
    end
    enable = 1'b0;
  endtask

  task automatic test_serial_order();
    logic [15:0] pat = 16'hA53C;
    logic [0:0]  e;
    int strobes = 0;
    do_reset();
    push_byte(8'hA5);
    push_byte(8'h3C);
    for (int i = 0; i < 16; i++) exp_q.push_back(pat[15-i]);
    enable = 1'b1;
    clrUnderflow = 1'b1;
    cycle();
    clrUnderflow = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    for (int c = 0; c < 200 && strobes < 16; c++) begin
      bitEn = (c % 4 == 0);
      cycle();
      vec_cnt++;
      if (act_v !== exp_v) begin
        err_cnt++;
        $display("FAIL serial_model cyc %0d: got %b expected %b", c, act_v, exp_v);
      end
      if (bitStrobe) begin
        strobes++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          vec_cnt++;
          if ({bitOut, bitIsData} !== {e, 1'b1}) begin
            err_cnt++;
            $display("FAIL serial_bit %0d: got bit=%b data=%b expected bit=%b data=1", strobes, bitOut, bitIsData, e);
          end
        end
      end
    end
    bitEn = 1'b0;
    vec_cnt++;
    if (strobes !== 16) begin
      err_cnt++;
      $display("FAIL serial_strobe_count: got %0d expected 16", strobes);
    end
    vec_cnt++;
    if (underflow !== 1'b0) begin
      err_cnt++;
      $display("FAIL serial_underflow: got %b expected 0", underflow);
    end
    enable = 1'b0;
  endtask

  task automatic test_underflow();
    logic [15:0] pat = 16'hFF55;
    int strobes = 0;
    do_reset();
    push_byte(8'hFF);
    enable = 1'b1;
    clrUnderflow = 1'b1;
    cycle();
    clrUnderflow = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    for (int c = 0; c < 100 && strobes < 16; c++) begin
      bitEn = (c % 2 == 0);
      cycle();
      vec_cnt++;
      if (act_v !== exp_v) begin
        err_cnt++;
        $display("FAIL underflow_model cyc %0d: got %b expected %b", c, act_v, exp_v);
      end
      if (bitStrobe) begin
        vec_cnt++;
        if (strobes < 16 && {bitOut, bitIsData} !== {pat[15-strobes], (strobes < 8) ? 1'b1 : 1'b0}) begin
          err_cnt++;
          $display("FAIL underflow_bit %0d: got bit=%b data=%b expected bit=%b data=%b",
                   strobes, bitOut, bitIsData, pat[15-strobes], (strobes < 8) ? 1'b1 : 1'b0);
        end
        strobes++;
      end
    end
    bitEn = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    vec_cnt++;
    if ({strobes == 16, underflow} !== 2'b11) begin
      err_cnt++;
      $display("FAIL underflow_sticky: got strobes=%0d uf=%b expected 16/1", strobes, underflow);
    end
    clrUnderflow = 1'b1;
    cycle();
    clrUnderflow = 1'b0;
    vec_cnt++;
    if (underflow !== 1'b0) begin
      err_cnt++;
      $display("FAIL underflow_clear: got %b expected 0", underflow);
    end
    // Boundary fill load and clear on the same clock: clear wins.
    bitEn = 1'b1;
    clrUnderflow = 1'b1;
    cycle();
    clrUnderflow = 1'b0;
    bitEn = 1'b0;
    vec_cnt++;
    if ({bitStrobe, bitIsData, underflow} !== 3'b100) begin
      err_cnt++;
      $display("FAIL underflow_clr_priority: got strobe/data/uf=%b expected 100", {bitStrobe, bitIsData, underflow});
    end
    cycle();
    vec_cnt++;
    if (underflow !== 1'b0) begin
      err_cnt++;
      $display("FAIL underflow_after_priority: got %b expected 0", underflow);
    end
    enable = 1'b0;
  endtask

  task automatic test_clken_gating();
    int rd_edges = 0;
    int qual_edges = 0;
    int strobes = 0;
    logic rd_before;
    do_reset();
    push_byte(8'h3C);
    enable = 1'b1;
    bitEn = 1'b1;
    for (int c = 0; c < 30; c++) begin
      clkEn = (c % 3 == 0);
      rd_before = fifoRdEn;
      if (clkEn) qual_edges++;
      cycle();
      if (rd_before && clkEn) rd_edges++;
      if (bitStrobe) strobes++;
      vec_cnt++;
      if (act_v !== exp_v) begin
        err_cnt++;
        $display("FAIL clken_model cyc %0d: got %b expected %b", c, act_v, exp_v);
      end
    end
    clkEn = 1'b1;
    bitEn = 1'b0;
    vec_cnt++;
    if (rd_edges !== 1) begin
      err_cnt++;
      $display("FAIL clken_rden_qualified: got %0d expected 1", rd_edges);
    end
    vec_cnt++;
    if (strobes !== qual_edges) begin
      err_cnt++;
      $display("FAIL clken_strobe_count: got %0d expected %0d", strobes, qual_edges);
    end
    enable = 1'b0;
  endtask

  task automatic test_enable_drop();
    logic [10:0] pat = {3'b101, 8'h96};
    int strobes = 0;
    do_reset();
    push_byte(8'hA5);
    enable = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    push_byte(8'h96);
    bitEn = 1'b1;
    for (int c = 0; c < 60 && strobes < 11; c++) begin
      if (strobes == 3 && c < 20) enable = 1'b0;
      else enable = 1'b1;
      cycle();
      vec_cnt++;
      if (act_v !== exp_v) begin
        err_cnt++;
        $display("FAIL enable_drop_model cyc %0d: got %b expected %b", c, act_v, exp_v);
      end
      if (bitStrobe) begin
        vec_cnt++;
        if (strobes < 11 && {bitOut, bitIsData} !== {pat[10-strobes], 1'b1}) begin
          err_cnt++;
          $display("FAIL enable_drop_bit %0d: got bit=%b data=%b expected bit=%b data=1",
                   strobes, bitOut, bitIsData, pat[10-strobes]);
        end
        strobes++;
      end
    end
    bitEn = 1'b0;
    vec_cnt++;
    if (strobes !== 11) begin
      err_cnt++;
      $display("FAIL enable_drop_count: got %0d expected 11", strobes);
    end
    enable = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    int strobes = 0;
    do_reset();
    push_byte(8'hFF);
    push_byte(8'h5A);
    enable = 1'b1;
    for (int c = 0; c < 40 && !(strobes >= 9 && m_cd == 2); c++) begin
      bitEn = (strobes < 9);
      cycle();
      if (bitStrobe) strobes++;
      vec_cnt++;
      if (act_v !== exp_v) begin
        err_cnt++;
        $display("FAIL mid_fetch_model cyc %0d: got %b expected %b", c, act_v, exp_v);
      end
    end
    bitEn = 1'b0;
    vec_cnt++;
    if ({dbg_state, bitOut, underflow} !== {2'd2, 2'b11}) begin
      err_cnt++;
      $display("FAIL mid_fetch_setup: got state=%0d bit=%b uf=%b expected 2/1/1", dbg_state, bitOut, underflow);
    end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    vec_cnt++;
    if ({fifoRdEn, bitOut, underflow, dbg_hold_valid, dbg_state} !== 6'b0) begin
      err_cnt++;
      $display("FAIL mid_fetch_reset: got rd/bit/uf/hv/st=%b expected 000000",
               {fifoRdEn, bitOut, underflow, dbg_hold_valid, dbg_state});
    end
    cycle();
    vec_cnt++;
    if (act_v !== exp_v) begin
      err_cnt++;
      $display("FAIL mid_fetch_after: got %b expected %b", act_v, exp_v);
    end
    enable = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    enable = 1'b1;
    for (int c = 0; c < 600; c++) begin
      clkEn = ($urandom_range(0, 3) != 0);
      bitEn = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 40) == 0) enable = ~enable;
      clrUnderflow = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 5) == 0 && fifo_q.size() < 16) push_byte(8'($urandom_range(0, 255)));
      cycle();
      vec_cnt++;
      if (act_v !== exp_v) begin
        err_cnt++;
        $display("FAIL random_model cyc %0d: got %b expected %b", c, act_v, exp_v);
      end
      if (m_hold_valid) begin
        vec_cnt++;
        if (dbg_hold_byte !== m_hold_q[0]) begin
          err_cnt++;
          $display("FAIL random_hold_byte cyc %0d: got %h expected %h", c, dbg_hold_byte, m_hold_q[0]);
        end
      end
    end
    clkEn = 1'b1; bitEn = 1'b0; clrUnderflow = 1'b0; enable = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    @(negedge clk);
    test_reset();
    test_fetch_timing();
    test_serial_order();
    test_underflow();
    test_clken_gating();
    test_enable_drop();
    test_reset_mid_fetch();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #500000;
    err_cnt++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/fifo_bit_serializer.md
Name: fifo_bit_serializer

Overview:
- Downstream consumer of the 8x16 byte FIFO in the telemetry output path.
- Pops bytes through the FIFO's registered read port.
- Holds one prefetched byte and shifts bits out serially, one bit per qualified bit-rate enable.
- When no data is available it substitutes a fill byte, so the output bit stream never stalls, and it flags that underflow.

Parameters:
FILL_BYTE  8'h55  byte shifted out when no FIFO data is held at a byte boundary
MSB_FIRST  1      1: bit 7 first; 0: bit 0 first

Ports:
clk           input   1  system clock
reset         input   1  synchronous, active-high reset
clkEn         input   1  clock enable; all state advances only when high (shared with FIFO)
enable        input   1  serializer run enable
bitEn         input   1  bit-rate strobe; qualified as clkEn & enable & bitEn
fifoEmpty     input   1  FIFO empty flag
fifoDout      input   8  FIFO registered read data
fifoRdEn      output  1  FIFO read request, registered
bitOut        output  1  serial data bit, registered
bitStrobe     output  1  one-clk pulse coincident with each new bitOut
bitIsData     output  1  1 = current bitOut came from a FIFO byte; 0 = fill
clrUnderflow  input   1  clears underflow (wins over a same-cycle set)
underflow     output  1  sticky: fill byte loaded since last clear

Behaviour:
Reset values:
- fifoRdEn=0, bitOut=0, bitStrobe=0, bitIsData=0, underflow=0.
- Fetch FSM in IDLE, holdValid=0, bitsLeft=0.

Fetch FSM (IDLE, READ, WAIT, CAP). All transitions require clkEn=1; with clkEn=0 the FSM holds state.
- IDLE: if enable & !holdValid & !fifoEmpty, go READ and set fifoRdEn=1.
- READ: fifoRdEn held high for exactly this one clkEn cycle. Go WAIT and set fifoRdEn=0.
- WAIT: go CAP. fifoDout now carries the popped byte (FIFO dout is one registered stage behind its read address).
- CAP: holdByte<=fifoDout, holdValid<=1, go IDLE.
- fifoEmpty is ignored in READ, WAIT and CAP, so at most one read is ever outstanding.
- Deasserting enable mid-fetch does not abort; the fetch completes into holdByte.
- fifoRdEn never asserts while fifoEmpty=1 in IDLE.

Shifter (on each qualified bitEn):
- If bitsLeft==0:
  - If holdValid: load holdByte and clear holdValid.
  - Otherwise: load FILL_BYTE and set underflow.
  - In both cases output the first bit this cycle and set bitsLeft=7.
- Otherwise: output the next bit and decrement bitsLeft.
- Bit order follows MSB_FIRST.
- bitStrobe=1 for that clk only. bitIsData is set per byte at load.
- No bypass: a CAP on the same edge as a byte-boundary bitEn does not feed that load. Fill is used, and the captured byte serves the next boundary.
- Without a qualified bitEn, bitOut and bitIsData hold and bitStrobe=0.

Other rules:
- enable=0: bitsLeft forced to 0 (a partial byte is discarded); holdByte/holdValid retained; bitOut holds.
- underflow sets even on the first byte after enable if no data is held. clrUnderflow has priority over a same-cycle set.
- Reset mid-fetch returns to IDLE with fifoRdEn=0. The popped byte is lost; this is acceptable because the FIFO is reset together with this block.
- Throughput: a fetch takes 3 clkEn cycles after IDLE. Sustained data without fill requires at least 4 clkEn cycles per 8 bitEn (always true when bitEn <= clkEn/1).

Test Plan:
- Empty-to-data fetch timing: FIFO holds 0xA5, clkEn=1 continuously, enable rises → fifoRdEn high for exactly 1 clk; holdByte=0xA5 three clks after fifoRdEn first asserts.
- Serial order: write 0xA5 then 0x3C, bitEn every 4th clk, MSB_FIRST=1 → bitOut sequence 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0; bitIsData=1 throughout; 16 bitStrobe pulses; underflow stays 0 after the initial clear.
- Underflow/fill: single byte 0xFF, then the FIFO runs dry → next 8 bits are 0,1,0,1,0,1,0,1 (0x55) with bitIsData=0; underflow=1 until clrUnderflow. Asserting clrUnderflow on the same clk as a fill load leaves underflow=0.
- clkEn gating: clkEn toggled 1-of-3 during a fetch → fifoRdEn stays high for exactly one clkEn-qualified cycle; FSM advances only on clkEn; bitEn with clkEn=0 is ignored.
- enable drop mid-byte: drop enable after 3 bits of 0xA5, hold 10 clks, re-enable → next load takes the held byte (or fill); remaining bits of 0xA5 are never emitted.
- Reset mid-fetch: assert reset in WAIT → next clk shows fifoRdEn=0, bitOut=0, underflow=0, FSM IDLE, holdValid=0.
